insdecode: RTL and testbench
============================

// Module: insdecode
// PURPOSE
// Decode stage directly downstream of instruction fetch. Takes the fetched word (i_data),
// tagged with trd_dec/pc_dec, and splits it into fields. Tracks per-thread pending load
// destinations in a scoreboard. Registers decoded instructions into the ID/EX pipeline
// register, and turns RAW-hazard instructions into bubbles plus a replay request to pc_sel.
// PARAMETERS
// NTRD     8   hardware threads (thread id width = $clog2(NTRD) = 3)
// NREG     32  architectural registers per thread; r0 is hard-wired zero, never pending
// PORTS
// clk         in   1   clock
// rst_n       in   1   async active-low reset
// i_data      in   32  fetched instruction for trd_dec
// pc_dec      in   32  pc of i_data
// trd_dec     in   3   thread of i_data
// i_miss      in   1   i_data invalid this cycle (icache miss)
// stall       in   1   hold ID/EX register and scoreboard sets
// flushID     in   1   squash instruction in ID (ex_valid<=0 next edge)
// wb_en       in   1   load writeback completes
// wb_trd      in   3   writeback thread
// wb_rd       in   5   writeback register
// kill        in   1   thread kill
// kill_trd    in   3   killed thread
// ex_valid    out  1   ID/EX holds a live instruction
// ex_trd      out  3   thread tag
// ex_pc       out  32  pc
// ex_op       out  6   opcode
// ex_rd/ex_rs1/ex_rs2  out 5 each  register indices
// ex_imm      out  32  sign-extended immediate
// ex_ld/ex_st/ex_br/ex_we/ex_illegal  out 1 each  decoded class flags
// replay      out  1   combinational: hazard, refetch replay_pc for replay_trd
// replay_trd  out  3   = trd_dec
// replay_pc   out  32  = pc_dec
// sb_busy     out  8   per-thread OR of pending bits
// BEHAVIOUR
// - Reset: every ex_* output 0, scoreboard all 0. replay and sb_busy therefore read 0.
// - Fields: op=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], imm=sext([15:1]) (bit0 is the fetch atomic flag).
//   Opcode classes come from the package. An unlisted opcode sets ex_illegal=1 and ex_we=0.
// - Latency: 1 cycle. ID/EX loads on every edge with !stall.
// - valid_in = !i_miss & !flushID. hazard = valid_in & (pend[trd][rs1] | pend[trd][rs2] | (ex_we & pend[trd][rd])).
//   pend is the registered scoreboard with the same-cycle wb clear bypassed in (wb clear is visible immediately).
// - replay = hazard & !stall. On hazard the ID/EX register loads a bubble (ex_valid=0, all flags 0).
// - Scoreboard set: accepted (valid_in & !hazard & !stall) load with rd!=0 sets pend[trd][rd].
// - Scoreboard clear: wb_en clears pend[wb_trd][wb_rd]. Clear is applied even during stall.
// - Same edge, same thread/reg: set wins over wb clear.
// - kill clears the whole pend[kill_trd] row, and beats a same-edge set to that row.
//   If ex_trd==kill_trd, ex_valid<=0.
// - stall: ID/EX holds, no set, replay=0. flushID overrides stall and forces ex_valid 0.
// - Reset asserted mid-operation: everything returns to reset values at once (async); no replay fires.
// STRUCTURE
// - Package (kraken_pkg): opcode localparams, op-class enum, field bit positions, TRD_W=3.
// - Sub-module scoreboard (NTRD x NREG bits).
//   Ports: set_en/set_trd/set_rd, clr_en/clr_trd/clr_rd, kill/kill_trd, 3 read ports with bypass, busy vector.
// - insdecode holds the field decode, the hazard logic and the ID/EX register.
// TESTING
// - Reset: hold rst_n=0 with random inputs -> ex_valid=0, replay=0, sb_busy=8'h00.
// - Load r5 on trd 2 accepted, then add r6,r5,r1 on trd 2 next cycle
//   -> replay=1, replay_pc=pc_dec, ex_valid=0 after the edge; sb_busy=8'h04.
// - Same as above but trd 3 reads r5 -> no hazard, ex_valid=1.
//   Then wb_en trd2/r5 in the same cycle as the trd 2 reread -> no replay, sb_busy=0.
// - Load r7 (trd 1) accepted on the same edge as wb_en trd1/r7 -> pend stays set, sb_busy[1]=1.
//   kill trd 1 -> sb_busy[1]=0.
// - stall=1 for 3 cycles with a hazard present -> replay=0, ex_* unchanged.
//   flushID during stall -> ex_valid=0.
// - i_miss=1 -> bubble, no scoreboard change.
//   Unlisted opcode 6'h3F -> ex_illegal=1, ex_we=0.

Source files
------------

// File: rtl/kraken_pkg.sv
// Shared decode definitions: thread/register sizing, field positions, opcodes,
// the opcode-class table and the ID/EX pipeline register layout.
package kraken_pkg;

  localparam int NTRD  = 8;
  localparam int NREG  = 32;
  localparam int TRD_W = 3;
  localparam int REG_W = 5;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 1;

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_BR   = 6'h04;
  localparam logic [5:0] OP_JAL  = 6'h05;
  localparam logic [5:0] OP_NOP  = 6'h06;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_NOP
  } op_class_e;

  typedef struct packed {
    logic ld;
    logic st;
    logic br;
    logic we;
    logic illegal;
  } dec_flags_t;

  typedef struct packed {
    logic             valid;
    logic [TRD_W-1:0] trd;
    logic [31:0]      pc;
    logic [5:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [31:0]      imm;
    dec_flags_t       flags;
  } ex_t;

  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_ALU, OP_ADDI: return CLS_ALU;
      OP_LD:           return CLS_LOAD;
      OP_ST:           return CLS_STORE;
      OP_BR:           return CLS_BRANCH;
      OP_JAL:          return CLS_JUMP;
      OP_NOP:          return CLS_NOP;
      default:         return CLS_ILLEGAL;
    endcase
  endfunction

  // Jumps write the link register, so they carry both br and we.
  function automatic dec_flags_t class_flags(input op_class_e cls);
    dec_flags_t f;
    f = '0;
    case (cls)
      CLS_ALU:    f.we = 1'b1;
      CLS_LOAD:   begin f.ld = 1'b1; f.we = 1'b1; end
      CLS_STORE:  f.st = 1'b1;
      CLS_BRANCH: f.br = 1'b1;
      CLS_JUMP:   begin f.br = 1'b1; f.we = 1'b1; end
      CLS_NOP:    f = '0;
      default:    f.illegal = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/insdecode_if.sv
// Fetch-to-decode input bundle and the ID/EX / replay output bundle.
interface insdecode_if;
  import kraken_pkg::*;

  logic [31:0]      i_data;
  logic [31:0]      pc_dec;
  logic [TRD_W-1:0] trd_dec;
  logic             i_miss;

  logic             ex_valid;
  logic [TRD_W-1:0] ex_trd;
  logic [31:0]      ex_pc;
  logic [5:0]       ex_op;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] ex_rs1;
  logic [REG_W-1:0] ex_rs2;
  logic [31:0]      ex_imm;
  logic             ex_ld;
  logic             ex_st;
  logic             ex_br;
  logic             ex_we;
  logic             ex_illegal;

  logic             replay;
  logic [TRD_W-1:0] replay_trd;
  logic [31:0]      replay_pc;

  modport master (
    output i_data, pc_dec, trd_dec, i_miss,
    input  ex_valid, ex_trd, ex_pc, ex_op, ex_rd, ex_rs1, ex_rs2, ex_imm,
    input  ex_ld, ex_st, ex_br, ex_we, ex_illegal,
    input  replay, replay_trd, replay_pc
  );

  modport slave (
    input  i_data, pc_dec, trd_dec, i_miss,
    output ex_valid, ex_trd, ex_pc, ex_op, ex_rd, ex_rs1, ex_rs2, ex_imm,
    output ex_ld, ex_st, ex_br, ex_we, ex_illegal,
    output replay, replay_trd, replay_pc
  );

endinterface

// File: rtl/insdecode_scoreboard.sv
// Per-thread pending-load scoreboard; reads see a same-cycle writeback clear.
module insdecode_scoreboard
  import kraken_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [TRD_W-1:0] set_trd,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [TRD_W-1:0] clr_trd,
  input  logic [REG_W-1:0] clr_rd,
  input  logic             kill,
  input  logic [TRD_W-1:0] kill_trd,
  input  logic [TRD_W-1:0] rd_trd,
  input  logic [REG_W-1:0] rd_rs1,
  input  logic [REG_W-1:0] rd_rs2,
  input  logic [REG_W-1:0] rd_rd,
  output logic             pend_rs1,
  output logic             pend_rs2,
  output logic             pend_rd,
  output logic [NTRD-1:0]  busy
);

  logic [NTRD-1:0][NREG-1:0] pend, pend_nxt;

  // Priority low to high: writeback clear, then set, then kill of the whole row.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_trd][clr_rd] = 1'b0;
    if (set_en) pend_nxt[set_trd][set_rd] = 1'b1;
    if (kill)   pend_nxt[kill_trd] = '0;
    for (int t = 0; t < NTRD; t++) pend_nxt[t][0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign pend_rs1 = pend[rd_trd][rd_rs1] &
                    ~(clr_en && clr_trd == rd_trd && clr_rd == rd_rs1);
  assign pend_rs2 = pend[rd_trd][rd_rs2] &
                    ~(clr_en && clr_trd == rd_trd && clr_rd == rd_rs2);
  assign pend_rd  = pend[rd_trd][rd_rd] &
                    ~(clr_en && clr_trd == rd_trd && clr_rd == rd_rd);

  always_comb begin
    busy = '0;
    for (int t = 0; t < NTRD; t++) busy[t] = |pend[t];
  end

endmodule

// File: rtl/insdecode.sv
// Decode stage: field split, RAW/WAW hazard check against pending loads,
// replay request and the ID/EX pipeline register.
module insdecode
  import kraken_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  insdecode_if.slave       dec,
  input  logic             stall,
  input  logic             flushID,
  input  logic             wb_en,
  input  logic [TRD_W-1:0] wb_trd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             kill,
  input  logic [TRD_W-1:0] kill_trd,
  output logic [NTRD-1:0]  sb_busy
);

  logic [5:0]       op;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [31:0]      imm;
  dec_flags_t       flags;
  logic             pend_rs1, pend_rs2, pend_rd;
  logic             valid_in, hazard, accept, set_en;
  ex_t              ex_q, ex_d;

  assign op    = dec.i_data[OP_HI:OP_LO];
  assign rd    = dec.i_data[RD_HI:RD_LO];
  assign rs1   = dec.i_data[RS1_HI:RS1_LO];
  assign rs2   = dec.i_data[RS2_HI:RS2_LO];
  assign imm   = {{(32-(IMM_HI-IMM_LO+1)){dec.i_data[IMM_HI]}}, dec.i_data[IMM_HI:IMM_LO]};
  assign flags = class_flags(op_class(op));

  // The rd check uses the decoded instruction's own write enable (WAW on a pending load).
  assign valid_in = !dec.i_miss && !flushID;
  assign hazard   = valid_in && (pend_rs1 || pend_rs2 || (flags.we && pend_rd));
  assign accept   = valid_in && !hazard && !stall;
  assign set_en   = accept && flags.ld && (rd != '0);

  insdecode_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_trd  (dec.trd_dec),
    .set_rd   (rd),
    .clr_en   (wb_en),
    .clr_trd  (wb_trd),
    .clr_rd   (wb_rd),
    .kill     (kill),
    .kill_trd (kill_trd),
    .rd_trd   (dec.trd_dec),
    .rd_rs1   (rs1),
    .rd_rs2   (rs2),
    .rd_rd    (rd),
    .pend_rs1 (pend_rs1),
    .pend_rs2 (pend_rs2),
    .pend_rd  (pend_rd),
    .busy     (sb_busy)
  );

  // Bubbles still carry the decoded fields; only valid and the class flags are zeroed.
  always_comb begin
    ex_d = ex_q;
    if (!stall) begin
      ex_d.valid = accept;
      ex_d.trd   = dec.trd_dec;
      ex_d.pc    = dec.pc_dec;
      ex_d.op    = op;
      ex_d.rd    = rd;
      ex_d.rs1   = rs1;
      ex_d.rs2   = rs2;
      ex_d.imm   = imm;
      ex_d.flags = accept ? flags : '0;
    end else if (flushID) begin
      ex_d.valid = 1'b0;
      ex_d.flags = '0;
    end
    if (kill && ex_d.trd == kill_trd) begin
      ex_d.valid = 1'b0;
      ex_d.flags = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign dec.ex_valid   = ex_q.valid;
  assign dec.ex_trd     = ex_q.trd;
  assign dec.ex_pc      = ex_q.pc;
  assign dec.ex_op      = ex_q.op;
  assign dec.ex_rd      = ex_q.rd;
  assign dec.ex_rs1     = ex_q.rs1;
  assign dec.ex_rs2     = ex_q.rs2;
  assign dec.ex_imm     = ex_q.imm;
  assign dec.ex_ld      = ex_q.flags.ld;
  assign dec.ex_st      = ex_q.flags.st;
  assign dec.ex_br      = ex_q.flags.br;
  assign dec.ex_we      = ex_q.flags.we;
  assign dec.ex_illegal = ex_q.flags.illegal;

  assign dec.replay     = hazard && !stall;
  assign dec.replay_trd = dec.trd_dec;
  assign dec.replay_pc  = dec.pc_dec;

endmodule

// File: tb/tb_insdecode.sv
// Directed bench for insdecode: a per-cycle reference model plus hand-computed checkpoints.
module tb_insdecode;
  import kraken_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       stall, flushID, wb_en, kill;
  logic [2:0] wb_trd, kill_trd;
  logic [4:0] wb_rd;
  logic [7:0] sb_busy;
  int         n_checks;
  int         n_fail;

  insdecode_if bus ();

  insdecode dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec      (bus),
    .stall    (stall),
    .flushID  (flushID),
    .wb_en    (wb_en),
    .wb_trd   (wb_trd),
    .wb_rd    (wb_rd),
    .kill     (kill),
    .kill_trd (kill_trd),
    .sb_busy  (sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h000};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [14:0] imm);
    return {op, rd, rs1, imm, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set per thread and the expected ID/EX contents.
  bit         mp [8][32];
  logic       m_valid;
  logic [2:0] m_trd;
  logic [31:0] m_pc, m_imm;
  logic [5:0] m_op;
  logic [4:0] m_rd, m_rs1, m_rs2;
  logic [4:0] m_flags;

  // {ld, st, br, we, illegal} for each opcode in the instruction set.
  function automatic logic [4:0] ref_flags(input logic [5:0] op);
    case (op)
      6'h00:   return 5'b00010;
      6'h01:   return 5'b00010;
      6'h02:   return 5'b10010;
      6'h03:   return 5'b01000;
      6'h04:   return 5'b00100;
      6'h05:   return 5'b00110;
      6'h06:   return 5'b00000;
      default: return 5'b00001;
    endcase
  endfunction

  function automatic bit seen(input logic [2:0] t, input logic [4:0] r);
    return mp[t][r] && !(wb_en && wb_trd == t && wb_rd == r);
  endfunction

  function automatic bit ref_hazard();
    logic [31:0] w;
    logic [4:0]  f;
    w = bus.i_data;
    f = ref_flags(w[31:26]);
    return !bus.i_miss && !flushID &&
           (seen(bus.trd_dec, w[20:16]) || seen(bus.trd_dec, w[15:11]) ||
            (f[1] && seen(bus.trd_dec, w[25:21])));
  endfunction

  function automatic logic [7:0] ref_busy();
    logic [7:0] b;
    b = '0;
    for (int t = 0; t < 8; t++)
      for (int r = 0; r < 32; r++)
        if (mp[t][r]) b[t] = 1'b1;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] w;
    logic [4:0]  f;
    bit          hz, acc;
    if (!rst_n) begin
      for (int t = 0; t < 8; t++)
        for (int r = 0; r < 32; r++) mp[t][r] = 1'b0;
      {m_valid, m_trd, m_pc, m_imm, m_op, m_rd, m_rs1, m_rs2, m_flags} = '0;
    end else begin
      w   = bus.i_data;
      f   = ref_flags(w[31:26]);
      hz  = ref_hazard();
      acc = !bus.i_miss && !flushID && !hz && !stall;
      if (wb_en) mp[wb_trd][wb_rd] = 1'b0;
      if (acc && f[4] && w[25:21] != 5'd0) mp[bus.trd_dec][w[25:21]] = 1'b1;
      if (kill)
        for (int r = 0; r < 32; r++) mp[kill_trd][r] = 1'b0;
      if (!stall) begin
        m_valid = acc;
        m_trd   = bus.trd_dec;
        m_pc    = bus.pc_dec;
        m_op    = w[31:26];
        m_rd    = w[25:21];
        m_rs1   = w[20:16];
        m_rs2   = w[15:11];
        m_imm   = 32'($signed(w[15:1]));
        m_flags = acc ? f : 5'b0;
      end else if (flushID) begin
        m_valid = 1'b0;
        m_flags = 5'b0;
      end
      if (kill && m_trd == kill_trd) begin
        m_valid = 1'b0;
        m_flags = 5'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_replay;
    exp_replay = ref_hazard() && !stall;
    checkOutput("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    checkOutput("ex_flags", 32'({bus.ex_ld, bus.ex_st, bus.ex_br, bus.ex_we, bus.ex_illegal}),
                32'(m_flags));
    checkOutput("replay", 32'(bus.replay), 32'(exp_replay));
    checkOutput("sb_busy", 32'(sb_busy), 32'(ref_busy()));
    if (exp_replay) begin
      checkOutput("replay_pc", bus.replay_pc, bus.pc_dec);
      checkOutput("replay_trd", 32'(bus.replay_trd), 32'(bus.trd_dec));
    end
    if (m_valid) begin
      checkOutput("ex_trd", 32'(bus.ex_trd), 32'(m_trd));
      checkOutput("ex_pc", bus.ex_pc, m_pc);
      checkOutput("ex_op", 32'(bus.ex_op), 32'(m_op));
      checkOutput("ex_regs", 32'({bus.ex_rd, bus.ex_rs1, bus.ex_rs2}), 32'({m_rd, m_rs1, m_rs2}));
      checkOutput("ex_imm", bus.ex_imm, m_imm);
    end
  end

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [2:0] trd, input logic miss,
                               input logic st, input logic fl,
                               input logic wbe, input logic [2:0] wbt, input logic [4:0] wbr,
                               input logic kl, input logic [2:0] kt);
    bus.i_data  = instr;
    bus.pc_dec  = pc;
    bus.trd_dec = trd;
    bus.i_miss  = miss;
    stall       = st;
    flushID     = fl;
    wb_en       = wbe;
    wb_trd      = wbt;
    wb_rd       = wbr;
    kill        = kl;
    kill_trd    = kt;
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] trd);
    applyStimulus(instr, pc, trd, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic idle();
    applyStimulus(32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom, $urandom, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom), 3'($urandom));
      checkOutput("rst_replay", 32'(bus.replay), 32'd0);
      tick();
      checkOutput("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      checkOutput("rst_sb_busy", 32'(sb_busy), 32'h00);
    end
    idle();
    rst_n = 1'b1;
    tick();

    // Load r5 on thread 2, then a dependent add on thread 2.
    issue(mk_i(OP_LD, 5'd5, 5'd1, 15'h7FF0), 32'h100, 3'd2);
    checkOutput("ld_replay", 32'(bus.replay), 32'd0);
    tick();
    checkOutput("ld_valid", 32'(bus.ex_valid), 32'd1);
    checkOutput("ld_imm", bus.ex_imm, 32'hFFFF_FFF0);
    checkOutput("ld_busy", 32'(sb_busy), 32'h04);
    issue(mk_r(OP_ALU, 5'd6, 5'd5, 5'd1), 32'h104, 3'd2);
    checkOutput("raw_replay", 32'(bus.replay), 32'd1);
    checkOutput("raw_replay_pc", bus.replay_pc, 32'h104);
    tick();
    checkOutput("raw_bubble", 32'(bus.ex_valid), 32'd0);
    checkOutput("raw_busy", 32'(sb_busy), 32'h04);

    // Same add on thread 3 is independent; thread 2 retries with writeback bypass.
    issue(mk_r(OP_ALU, 5'd6, 5'd5, 5'd1), 32'h200, 3'd3);
    checkOutput("t3_replay", 32'(bus.replay), 32'd0);
    tick();
    checkOutput("t3_valid", 32'(bus.ex_valid), 32'd1);
    checkOutput("t3_trd", 32'(bus.ex_trd), 32'd3);
    applyStimulus(mk_r(OP_ALU, 5'd6, 5'd5, 5'd1), 32'h104, 3'd2, 1'b0, 1'b0, 1'b0,
                  1'b1, 3'd2, 5'd5, 1'b0, 3'd0);
    checkOutput("bypass_replay", 32'(bus.replay), 32'd0);
    tick();
    checkOutput("bypass_valid", 32'(bus.ex_valid), 32'd1);
    checkOutput("bypass_busy", 32'(sb_busy), 32'h00);

    // Set beats same-edge clear; kill wipes the row and the killed thread's slot.
    applyStimulus(mk_i(OP_LD, 5'd7, 5'd2, 15'h0008), 32'h300, 3'd1, 1'b0, 1'b0, 1'b0,
                  1'b1, 3'd1, 5'd7, 1'b0, 3'd0);
    tick();
    checkOutput("setwin_busy", 32'(sb_busy), 32'h02);
    applyStimulus(mk_r(OP_ALU, 5'd8, 5'd2, 5'd3), 32'h304, 3'd1, 1'b0, 1'b0, 1'b0,
                  1'b0, 3'd0, 5'd0, 1'b1, 3'd1);
    tick();
    checkOutput("kill_busy", 32'(sb_busy), 32'h00);
    checkOutput("kill_valid", 32'(bus.ex_valid), 32'd0);

    // Stall with a hazard present, then flush during the stall.
    issue(mk_i(OP_LD, 5'd9, 5'd0, 15'h0004), 32'h400, 3'd4);
    tick();
    checkOutput("ld9_busy", 32'(sb_busy), 32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk_r(OP_ALU, 5'd10, 5'd9, 5'd0), 32'h404, 3'd4, 1'b0, 1'b1, 1'b0,
                    1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
      checkOutput("stall_replay", 32'(bus.replay), 32'd0);
      tick();
      checkOutput("stall_hold_pc", bus.ex_pc, 32'h400);
      checkOutput("stall_hold_valid", 32'(bus.ex_valid), 32'd1);
    end
    applyStimulus(mk_r(OP_ALU, 5'd10, 5'd9, 5'd0), 32'h404, 3'd4, 1'b0, 1'b1, 1'b1,
                  1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
    tick();
    checkOutput("flush_valid", 32'(bus.ex_valid), 32'd0);

    // Icache miss gives a bubble without touching the scoreboard.
    applyStimulus(mk_r(OP_ALU, 5'd10, 5'd9, 5'd0), 32'h404, 3'd4, 1'b1, 1'b0, 1'b0,
                  1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
    checkOutput("miss_replay", 32'(bus.replay), 32'd0);
    tick();
    checkOutput("miss_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("miss_busy", 32'(sb_busy), 32'h10);
    applyStimulus(32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 5'd9, 1'b0, 3'd0);
    tick();
    checkOutput("wb9_busy", 32'(sb_busy), 32'h00);

    // Unlisted opcode.
    issue({6'h3F, 5'd3, 5'd1, 5'd2, 11'h0}, 32'h500, 3'd0);
    tick();
    checkOutput("ill_valid", 32'(bus.ex_valid), 32'd1);
    checkOutput("ill_flag", 32'(bus.ex_illegal), 32'd1);
    checkOutput("ill_we", 32'(bus.ex_we), 32'd0);

    // WAW on a pending load; a store naming the same rd is not a writer.
    issue(mk_i(OP_LD, 5'd12, 5'd1, 15'h0002), 32'h600, 3'd5);
    tick();
    checkOutput("ld12_busy", 32'(sb_busy), 32'h20);
    issue(mk_i(OP_ADDI, 5'd12, 5'd1, 15'h0003), 32'h604, 3'd5);
    checkOutput("waw_replay", 32'(bus.replay), 32'd1);
    tick();
    issue(mk_r(OP_ST, 5'd12, 5'd1, 5'd2), 32'h608, 3'd5);
    checkOutput("st_replay", 32'(bus.replay), 32'd0);
    tick();
    checkOutput("st_flag", 32'(bus.ex_st), 32'd1);
    issue(mk_i(OP_LD, 5'd0, 5'd1, 15'h0000), 32'h700, 3'd6);
    tick();
    checkOutput("ld_r0_busy", 32'(sb_busy), 32'h20);
    issue(mk_r(OP_BR, 5'd0, 5'd3, 5'd4), 32'h704, 3'd6);
    tick();
    checkOutput("br_flag", 32'(bus.ex_br), 32'd1);

    // Asynchronous reset in the middle of a hazard.
    issue(mk_i(OP_ADDI, 5'd12, 5'd1, 15'h0003), 32'h604, 3'd5);
    checkOutput("pre_rst_replay", 32'(bus.replay), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_replay", 32'(bus.replay), 32'd0);
    checkOutput("async_rst_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(sb_busy), 32'h00);
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
